// File: rtl/ib_seq_ctrl.sv
// ib_seq_ctrl
//   Sequencer for a bank of NUM_IB input buffers. A job first clears all
//   buffers. It then loads them one after another from a single input
//   stream, VECTOR words per buffer. Finally it replays every buffer in
//   parallel REPLAY times toward the MAC array.
//
//   Buffer command encoding on ib_ctl[2k+1:2k]:
//     0 = idle (also rewinds the address), 1 = store, 2 = output, 3 = clear
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      pulse: begin a load/replay job (ignored while busy)
//   clear      abort: clear all buffers and return to idle (beats start)
//   in_valid   input word valid
//   in_data    input word
//   in_ready   high while the sequencer is loading
//   ib_ctl     per-buffer command, registered
//   ib_din     write data, aligned with ib_ctl
//   out_valid  buffer outputs hold valid data this cycle
//   out_last   with out_valid: last word of the last pass
//   busy       a job is in progress
//   done       one-cycle pulse after the last word of the last pass
//   err        sticky: a burst was interrupted; cleared by start/clear/rst
module ib_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int VECTOR = 4,
    parameter int NUM_IB = 4,
    parameter int REPLAY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic [2*NUM_IB-1:0]   ib_ctl,
    output logic [WIDTH-1:0]      ib_din,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int WC_W = $clog2(VECTOR) + 1;
    localparam int BI_W = $clog2(NUM_IB) + 1;
    localparam int PC_W = $clog2(REPLAY) + 1;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_STORE = 2'd1;
    localparam logic [1:0] CMD_OUT   = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_GAP,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   word_cnt;
    logic [BI_W-1:0]   buf_idx;
    logic [PC_W-1:0]   pass_cnt;
    logic [WC_W-1:0]   rd_cnt;
    logic              rd_vld_p0;
    logic              rd_last_p0;

    // Same command broadcast to every buffer.
    function automatic logic [2*NUM_IB-1:0] all_cmd(input logic [1:0] cmd);
        all_cmd = {NUM_IB{cmd}};
    endfunction

    // Store command to buffer idx, idle to all others.
    function automatic logic [2*NUM_IB-1:0] store_cmd(input logic [BI_W-1:0] idx);
        logic [2*NUM_IB-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_IB; k++) begin
            if (idx == BI_W'(k)) begin
                res[2*k +: 2] = CMD_STORE;
            end
        end
        store_cmd = res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            buf_idx    <= '0;
            pass_cnt   <= '0;
            rd_cnt     <= '0;
            rd_vld_p0  <= 1'b0;
            rd_last_p0 <= 1'b0;
            in_ready   <= 1'b0;
            ib_ctl     <= '0;
            ib_din     <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            busy       <= (state != S_IDLE);
            rd_vld_p0  <= 1'b0;
            rd_last_p0 <= 1'b0;

            // Stage p1: buffers present the word addressed by the p0 read
            // command, so valid/last trail the output command by one cycle.
            out_valid  <= rd_vld_p0;
            out_last   <= rd_last_p0;

            // Job completes once the final word has left the buffers.
            done       <= out_valid & out_last;

            if (clear) begin
                state     <= S_IDLE;
                ib_ctl    <= all_cmd(CMD_CLEAR);
                in_ready  <= 1'b0;
                err       <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b0;
                word_cnt  <= '0;
                buf_idx   <= '0;
                pass_cnt  <= '0;
                rd_cnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        ib_ctl <= all_cmd(CMD_IDLE);
                        // busy still reflects the previous job's tail cycle.
                        if (start && !busy) begin
                            state <= S_CLR;
                            err   <= 1'b0;
                        end
                    end

                    S_CLR: begin
                        ib_ctl   <= all_cmd(CMD_CLEAR);
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                        buf_idx  <= '0;
                        word_cnt <= '0;
                    end

                    S_LOAD: begin
                        if (in_valid) begin
                            ib_ctl <= store_cmd(buf_idx);
                            ib_din <= in_data;
                            if (word_cnt == WC_W'(VECTOR - 1)) begin
                                word_cnt <= '0;
                                buf_idx  <= buf_idx + 1'b1;
                                if (buf_idx == BI_W'(NUM_IB - 1)) begin
                                    state    <= S_GAP;
                                    in_ready <= 1'b0;
                                    pass_cnt <= '0;
                                end
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else if (word_cnt != '0) begin
                            // Burst broken mid-way: wipe the bank and abort.
                            err      <= 1'b1;
                            ib_ctl   <= all_cmd(CMD_CLEAR);
                            state    <= S_IDLE;
                            in_ready <= 1'b0;
                            word_cnt <= '0;
                        end else begin
                            // Waiting between bursts; idle also rewinds the
                            // buffer that just finished.
                            ib_ctl <= all_cmd(CMD_IDLE);
                        end
                    end

                    S_GAP: begin
                        ib_ctl <= all_cmd(CMD_IDLE);
                        rd_cnt <= '0;
                        state  <= S_OUT;
                    end

                    // Stage p0: read command issued to every buffer.
                    S_OUT: begin
                        ib_ctl     <= all_cmd(CMD_OUT);
                        rd_vld_p0  <= 1'b1;
                        rd_last_p0 <= (rd_cnt == WC_W'(VECTOR - 1)) &&
                                      (pass_cnt == PC_W'(REPLAY - 1));
                        if (rd_cnt == WC_W'(VECTOR - 1)) begin
                            rd_cnt <= '0;
                            if (pass_cnt == PC_W'(REPLAY - 1)) begin
                                state <= S_DONE;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                                state    <= S_GAP;
                            end
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        ib_ctl <= all_cmd(CMD_IDLE);
                        state  <= S_IDLE;
                    end

                    default: begin
                        ib_ctl <= all_cmd(CMD_IDLE);
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ib_seq_ctrl.sv
module tb_ib_seq_ctrl;

    localparam int W = 16;
    localparam int V = 4;
    localparam int N = 2;
    localparam logic [2*N-1:0] CTL_CLR = {N{2'b11}};
    localparam logic [2*N-1:0] CTL_OUT = {N{2'b10}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, clear, in_valid;
    logic [W-1:0] in_data;

    logic           a_in_ready, a_out_valid, a_out_last, a_busy, a_done, a_err;
    logic [2*N-1:0] a_ctl;
    logic [W-1:0]   a_din;
    logic           b_in_ready, b_out_valid, b_out_last, b_busy, b_done, b_err;
    logic [2*N-1:0] b_ctl;
    logic [W-1:0]   b_din;

    ib_seq_ctrl #(.WIDTH(W), .VECTOR(V), .NUM_IB(N), .REPLAY(1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .ib_ctl(a_ctl), .ib_din(a_din), .out_valid(a_out_valid),
        .out_last(a_out_last), .busy(a_busy), .done(a_done), .err(a_err)
    );

    ib_seq_ctrl #(.WIDTH(W), .VECTOR(V), .NUM_IB(N), .REPLAY(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .ib_ctl(b_ctl), .ib_din(b_din), .out_valid(b_out_valid),
        .out_last(b_out_last), .busy(b_busy), .done(b_done), .err(b_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit sel_b    = 1'b0;

    logic           s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_err;
    logic [2*N-1:0] s_ctl;
    logic [W-1:0]   s_din;

    typedef struct { logic [2*N-1:0] ctl; logic [W-1:0] din; } st_t;
    typedef struct { int ofs; logic last; } ob_t;
    st_t st_q[$];
    ob_t ob_q[$];

    function automatic logic [2*N-1:0] exp_store(input int idx);
        logic [2*N-1:0] r;
        r = '0;
        r[2*idx +: 2] = 2'b01;
        return r;
    endfunction

    // Advance one clock and sample the selected DUT 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sel_b) begin
            s_in_ready = b_in_ready; s_out_valid = b_out_valid; s_out_last = b_out_last;
            s_busy = b_busy; s_done = b_done; s_err = b_err; s_ctl = b_ctl; s_din = b_din;
        end else begin
            s_in_ready = a_in_ready; s_out_valid = a_out_valid; s_out_last = a_out_last;
            s_busy = a_busy; s_done = a_done; s_err = a_err; s_ctl = a_ctl; s_din = a_din;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel_b = 1'b0;
        rst = 1'b1; start = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 16'hFFFF;
        tick();
        tick();
        checks++; if (s_ctl !== '0) begin failures++; $display("FAIL reset_ib_ctl got=%h exp=0", s_ctl); end
        checks++; if (s_din !== '0) begin failures++; $display("FAIL reset_ib_din got=%h exp=0", s_din); end
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
        checks++; if (s_out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", s_out_last); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        checks++; if (s_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", s_done); end
        checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", s_err); end
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", s_in_ready); end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    // Full job: optional stall of stall_len cycles between burst 0 and 1,
    // optional stray start pulses during LOAD and OUT.
    task automatic run_job(input string name, input bit use_b, input int rep,
                           input int stall_len, input bit poke);
        int w, stall, last_store, done_cyc, ndone, nf, na;
        bit err_seen;
        st_t st;
        ob_t ob;
        sel_b = use_b;
        st_q.delete();
        ob_q.delete();
        for (int p = 0; p < rep; p++)
            for (int j = 0; j < V; j++)
                ob_q.push_back('{3 + p*(V+1) + j, (p == rep-1) && (j == V-1)});
        w = 0; stall = 0; last_store = -1000; done_cyc = -1; ndone = 0; nf = 0; na = 0;
        err_seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            in_valid = 1'b0;
            start    = 1'b0;
            if (s_in_ready && w < N*V) begin
                if (w == V && stall < stall_len) begin
                    stall++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = W'(w + 1);
                    st_q.push_back('{exp_store(w / V), W'(w + 1)});
                    w++;
                end
            end
            if (poke && (w == 3 || na == 1)) start = 1'b1;
            tick();
            if (s_ctl === CTL_CLR) nf++;
            else if (s_ctl === CTL_OUT) na++;
            else if (s_ctl !== '0) begin
                checks++;
                if (st_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_store unexpected ctl=%h din=%h", name, s_ctl, s_din);
                end else begin
                    st = st_q.pop_front();
                    if (s_ctl !== st.ctl || s_din !== st.din) begin
                        failures++;
                        $display("FAIL %s_store got ctl=%h din=%h exp ctl=%h din=%h",
                                 name, s_ctl, s_din, st.ctl, st.din);
                    end
                end
                last_store = cyc;
            end
            if (s_out_valid === 1'b1) begin
                checks++;
                if (ob_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_out unexpected out_valid at ofs=%0d", name, cyc - last_store);
                end else begin
                    ob = ob_q.pop_front();
                    if ((cyc - last_store) != ob.ofs || s_out_last !== ob.last) begin
                        failures++;
                        $display("FAIL %s_out got ofs=%0d last=%b exp ofs=%0d last=%b",
                                 name, cyc - last_store, s_out_last, ob.ofs, ob.last);
                    end
                end
            end
            if (s_done === 1'b1) begin ndone++; done_cyc = cyc; end
            if (s_err === 1'b1) err_seen = 1'b1;
            if (ndone > 0 && cyc >= done_cyc + 3) break;
        end
        checks++; if (w != N*V) begin failures++; $display("FAIL %s_words got=%0d exp=%0d", name, w, N*V); end
        checks++; if (st_q.size() != 0) begin failures++; $display("FAIL %s_stores_left got=%0d exp=0", name, st_q.size()); end
        checks++; if (ob_q.size() != 0) begin failures++; $display("FAIL %s_beats_left got=%0d exp=0", name, ob_q.size()); end
        checks++; if (nf != 1) begin failures++; $display("FAIL %s_clr_cycles got=%0d exp=1", name, nf); end
        checks++; if (na != rep*V) begin failures++; $display("FAIL %s_out_cmds got=%0d exp=%0d", name, na, rep*V); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, ndone); end
        checks++;
        if (done_cyc - last_store != 3 + (rep-1)*(V+1) + V) begin
            failures++;
            $display("FAIL %s_done_ofs got=%0d exp=%0d", name, done_cyc - last_store, 3 + (rep-1)*(V+1) + V);
        end
        checks++; if (err_seen) begin failures++; $display("FAIL %s_err got=1 exp=0", name); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%b exp=0", name, s_busy); end
    endtask

    task automatic test_basic();
        do_reset();
        run_job("basic", 1'b0, 1, 0, 1'b0);
    endtask

    task automatic test_replay();
        do_reset();
        run_job("replay", 1'b1, 3, 0, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        run_job("stall", 1'b0, 1, 5, 1'b0);
    endtask

    task automatic test_burst_gap();
        int w, nf, f_cyc, err_cyc, last_store, ndone;
        st_t st;
        do_reset();
        sel_b = 1'b0;
        st_q.delete();
        w = 0; nf = 0; f_cyc = -1; err_cyc = -1; last_store = -1000; ndone = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b0;
            if (s_in_ready && w < 2) begin
                in_valid = 1'b1;
                in_data  = W'(w + 1);
                st_q.push_back('{exp_store(0), W'(w + 1)});
                w++;
            end
            tick();
            if (s_ctl === CTL_CLR) begin nf++; f_cyc = cyc; end
            else if (s_ctl !== '0) begin
                checks++;
                if (st_q.size() == 0) begin
                    failures++;
                    $display("FAIL gap_store unexpected ctl=%h", s_ctl);
                end else begin
                    st = st_q.pop_front();
                    if (s_ctl !== st.ctl || s_din !== st.din) begin
                        failures++;
                        $display("FAIL gap_store got ctl=%h din=%h exp ctl=%h din=%h", s_ctl, s_din, st.ctl, st.din);
                    end
                end
                last_store = cyc;
            end
            if (s_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
            if (s_done === 1'b1) ndone++;
        end
        in_valid = 1'b0;
        checks++; if (nf != 2) begin failures++; $display("FAIL gap_clr_cycles got=%0d exp=2", nf); end
        checks++; if (f_cyc != last_store + 1) begin failures++; $display("FAIL gap_abort_ofs got=%0d exp=1", f_cyc - last_store); end
        checks++; if (err_cyc != f_cyc) begin failures++; $display("FAIL gap_err_cycle got=%0d exp=%0d", err_cyc, f_cyc); end
        checks++; if (ndone != 0) begin failures++; $display("FAIL gap_done got=%0d exp=0", ndone); end
        checks++; if (s_err !== 1'b1) begin failures++; $display("FAIL gap_err_sticky got=%b exp=1", s_err); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL gap_busy got=%b exp=0", s_busy); end
        checks++; if (s_ctl !== '0) begin failures++; $display("FAIL gap_ctl_idle got=%h exp=0", s_ctl); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (s_err !== 1'b0) begin failures++; $display("FAIL gap_err_cleared got=%b exp=0", s_err); end
    endtask

    task automatic test_clear_out();
        int w, na, ndone, nov;
        do_reset();
        sel_b = 1'b0;
        w = 0; na = 0; ndone = 0; nov = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60 && na < 2; c++) begin
            in_valid = 1'b0;
            if (s_in_ready && w < N*V) begin
                in_valid = 1'b1;
                in_data  = W'(w + 1);
                w++;
            end
            tick();
            if (s_ctl === CTL_OUT) na++;
        end
        in_valid = 1'b0;
        checks++; if (na != 2) begin failures++; $display("FAIL clr_reach_out got=%0d exp=2", na); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (s_ctl !== CTL_CLR) begin failures++; $display("FAIL clr_ctl got=%h exp=%h", s_ctl, CTL_CLR); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL clr_out_valid got=%b exp=0", s_out_valid); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", s_busy); end
        checks++; if (s_ctl !== '0) begin failures++; $display("FAIL clr_ctl_after got=%h exp=0", s_ctl); end
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_done === 1'b1) ndone++;
            if (s_out_valid === 1'b1) nov++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL clr_done got=%0d exp=0", ndone); end
        checks++; if (nov != 0) begin failures++; $display("FAIL clr_late_valid got=%0d exp=0", nov); end
    endtask

    task automatic test_start_ignored();
        int w;
        do_reset();
        run_job("poke", 1'b0, 1, 0, 1'b1);
        sel_b = 1'b0;
        w = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && w < 3; c++) begin
            in_valid = 1'b0;
            if (s_in_ready) begin
                in_valid = 1'b1;
                in_data  = W'(16'h0100 + w);
                w++;
            end
            tick();
        end
        in_valid = 1'b1;
        checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b exp=1", s_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (s_ctl !== '0) begin failures++; $display("FAIL midrst_ib_ctl got=%h exp=0", s_ctl); end
        checks++; if (s_din !== '0) begin failures++; $display("FAIL midrst_ib_din got=%h exp=0", s_din); end
        checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", s_in_ready); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", s_busy); end
        checks++; if (s_out_valid !== 1'b0 || s_out_last !== 1'b0 || s_done !== 1'b0 || s_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags got=%b%b%b%b exp=0000", s_out_valid, s_out_last, s_done, s_err);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        test_reset();
        test_basic();
        test_replay();
        test_stall();
        test_burst_gap();
        test_clear_out();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
